rr_request_agent: RTL and testbench
===================================

RR_REQUEST_AGENT -- requirements
Module: rr_request_agent

Interface
REQ-001: Parameter NREQ, default 4, SHALL set the number of requester clients; only 4 is supported.
REQ-002: Parameter LW, default 4, SHALL set the job-length width in service cycles.
REQ-003: Parameter QDEPTH, default 2, SHALL set the job-queue depth per client.
REQ-004: Port clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-005: Port rst, input, 1, SHALL be a synchronous, active-low reset.
REQ-006: Port job_valid, input, 1, SHALL mark a job offer on the current cycle.
REQ-007: Port job_id, input, 2, SHALL select the target client for the offered job.
REQ-008: Port job_len, input, LW, SHALL give the job's service length in granted cycles.
REQ-009: Port job_ready, output, 1, SHALL be high when the queue of the client selected by job_id is not full.
REQ-010: Port gnt, input, 4, SHALL be the one-hot grant vector driven by the arbiter.
REQ-011: Port req, output, 4, SHALL be the registered per-client request vector presented to the arbiter.
REQ-012: Port done, output, 4, SHALL give a one-cycle registered pulse per client at job completion.
REQ-013: Port err, output, 1, SHALL be a sticky protocol-error flag.

Function
REQ-014: A job SHALL be accepted on a rising edge where job_valid and job_ready are both high, and pushed into the queue of client job_id.
REQ-015: job_ready SHALL be combinational from job_id and the queue occupancy.
REQ-016: job_len of 0 SHALL be stored as 1.
REQ-017: Each client SHALL run an independent FSM with states IDLE, WAIT and SERV.
REQ-018: In IDLE, a client with a non-empty queue SHALL move to WAIT, load remaining from the queue head, and assert req[i].
- req[i] first rises on the edge after acceptance when the client was IDLE with an empty queue.
REQ-019: In WAIT, req[i] SHALL stay high.
- An edge sampling gnt[i]=1 SHALL count as the first service cycle: move to SERV and decrement remaining.
REQ-020: In SERV, every edge sampling gnt[i]=1 SHALL decrement remaining.
REQ-021: In SERV, an edge sampling gnt[i]=0 (preemption) SHALL return the client to WAIT with remaining unchanged and req[i] still high.
REQ-022: On the edge where remaining decrements from 1 to 0, the client SHALL:
- pop its queue head;
- pulse done[i] high for the following cycle;
- go to WAIT with the next length loaded (req[i] stays high) if the queue is still non-empty after the pop, otherwise go to IDLE with req[i]=0.
REQ-023: A job length L served by an uninterrupted grant SHALL occupy exactly L grant cycles, with done[i] high on cycle L+1.
REQ-024: A push and a pop on the same client in the same cycle SHALL both take effect, with occupancy unchanged.
- A push into a full queue is blocked by job_ready=0, and a same-cycle pop does not unblock it.
REQ-025: Queues SHALL be FIFO with wrap-around pointers; job order per client SHALL be preserved.
REQ-026: err SHALL set and stay high until reset if any edge samples:
- gnt with more than one bit high; or
- gnt[i]=1 while req[i]=0.
REQ-027: A grant to a non-requesting client SHALL NOT alter that client's state.
REQ-028: Clients SHALL NOT interact except through the shared job input port.

Reset
REQ-029: An edge sampling rst=0 SHALL clear the following, overriding any concurrent push, grant or pop:
- all queues (empty);
- all FSMs to IDLE;
- req to 4'b0000, done to 4'b0000, err to 0.
REQ-030: Reset mid-service SHALL discard in-flight and queued jobs with no done pulse.
REQ-031: During reset, job_ready SHALL still reflect the queue state, but no push SHALL occur.

Verification
REQ-032: Reset then idle -> req=0000, done=0000, err=0, and job_ready=1 for every job_id.
REQ-033: Push id=2, len=3; hold gnt=0100 from the edge req[2] rises -> three granted edges, done=0100 for one cycle, then req[2]=0.
REQ-034: Push id=0 len=2 and id=0 len=1; grant continuously -> done[0] pulses twice, 2 and then 1 grant cycles apart, with req[0] high throughout.
REQ-035: Push id=1 len=4; grant 2 cycles, drop gnt 3 cycles, grant again -> done[1] after 2 more grant cycles, and req[1] never drops early.
REQ-036: Fill client 3 with 2 jobs -> job_ready=0 for id=3; offering a third job with job_valid=1 leaves it unaccepted.
REQ-037: gnt=0011, or gnt=1000 while req=0000 -> err=1 and held; a subsequent rst=0 clears it; rst=0 mid-SERV clears all outputs.

Source files
------------

// File: rtl/rr_request_agent.sv
// rr_request_agent: per-client job queues feeding round-robin requests with preemptible service
module rr_request_agent #(
  parameter int NREQ   = 4,
  parameter int LW     = 4,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            job_valid,
  input  logic [1:0]      job_id,
  input  logic [LW-1:0]   job_len,
  output logic            job_ready,
  input  logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] req,
  output logic [NREQ-1:0] done,
  output logic            err
);
  localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SERV} state_t;
  state_t        st_q  [NREQ];
  logic [LW-1:0] rem_q [NREQ];
  logic [LW-1:0] mem_q [NREQ][QDEPTH];
  logic [PW-1:0] rd_q  [NREQ];
  logic [PW-1:0] wr_q  [NREQ];
  logic [CW-1:0] cnt_q [NREQ];
  logic [NREQ-1:0] req_q, done_q, push, g, fin;
  logic [LW-1:0] len_in;
  logic err_q, err_d;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(QDEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // push/grant/completion decode, ready lookup and sticky protocol-error detection
  always_comb begin
    push = '0;
    g    = '0;
    fin  = '0;
    len_in    = job_len == '0 ? LW'(1) : job_len;
    job_ready = cnt_q[job_id] != CW'(QDEPTH);
    err_d     = err_q | (|(gnt & (gnt - NREQ'(1)))) | (|(gnt & ~req_q));
    for (int i = 0; i < NREQ; i++) begin
      push[i] = job_valid && job_ready && job_id == 2'(i);
      g[i]    = gnt[i] && req_q[i];
      fin[i]  = g[i] && rem_q[i] == LW'(1);
    end
  end
  // per-client queue and IDLE/WAIT/SERV service FSM with registered req/done
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        st_q[i]  <= S_IDLE;
        rem_q[i] <= '0;
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      req_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= err_d;
      done_q <= fin;
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) begin
          mem_q[i][wr_q[i]] <= len_in;
          wr_q[i] <= nxt(wr_q[i]);
        end
        if (fin[i]) rd_q[i] <= nxt(rd_q[i]);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(fin[i]);
        if (st_q[i] == S_IDLE) begin
          if (cnt_q[i] != '0) begin
            st_q[i]  <= S_WAIT;
            rem_q[i] <= mem_q[i][rd_q[i]];
            req_q[i] <= 1'b1;
          end
        end else if (fin[i]) begin
          if (cnt_q[i] > CW'(1) || push[i]) begin
            st_q[i]  <= S_WAIT;
            rem_q[i] <= cnt_q[i] > CW'(1) ? mem_q[i][nxt(rd_q[i])] : len_in;
          end else begin
            st_q[i]  <= S_IDLE;
            rem_q[i] <= '0;
            req_q[i] <= 1'b0;
          end
        end else if (g[i]) begin
          st_q[i]  <= S_SERV;
          rem_q[i] <= rem_q[i] - LW'(1);
        end else begin
          st_q[i] <= S_WAIT;
        end
      end
    end
  end
  assign req  = req_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_rr_request_agent.sv
// tb_rr_request_agent: directed stimulus with a done-pulse scoreboard checked by an independent monitor
module tb_rr_request_agent;
  logic clk = 0, rst = 0, job_valid = 0;
  logic [1:0] job_id = 0;
  logic [3:0] job_len = 0, gnt = 0;
  logic job_ready, err;
  logic [3:0] req, done;
  int cyc = 0, checks = 0, errors = 0, c0 = 0;
  typedef struct {logic [3:0] d; int c;} exp_t;
  exp_t sb[$];

  rr_request_agent dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_id(job_id), .job_len(job_len),
    .job_ready(job_ready), .gnt(gnt), .req(req), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", n, got, want, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] id, input logic [3:0] len);
    job_valid = 1; job_id = id; job_len = len;
  endtask

  task automatic expect_done(input logic [3:0] d, input int c);
    exp_t e;
    e.d = d; e.c = c;
    sb.push_back(e);
  endtask

  // monitor: every done pulse must match the next scoreboard entry in value and cycle
  always @(negedge clk) begin
    if (done !== 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got=%b cyc=%0d", done, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (done !== e.d || cyc != e.c) begin
          errors++;
          $display("FAIL done_pulse got=%b@%0d exp=%b@%0d", done, cyc, e.d, e.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("rst_req", req, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_err", err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      job_id = 2'(i);
      #1 chk("rst_ready", job_ready, 1'b1);
    end
    rst = 1;
    step();
    // single job, uninterrupted grant
    offer(2, 3); step(); c0 = cyc; job_valid = 0;
    step(); chk("t1_req_rise", req, 4'b0100);
    gnt = 4'b0100; expect_done(4'b0100, c0 + 4);
    step(3); chk("t1_req_drop", req, 4'b0000);
    gnt = 0; chk("t1_err", err, 1'b0);
    // two queued jobs, back-to-back
    offer(0, 2); step(); c0 = cyc; offer(0, 1); step(); job_valid = 0;
    chk("t2_req_a", req, 4'b0001);
    gnt = 4'b0001; expect_done(4'b0001, c0 + 3); expect_done(4'b0001, c0 + 4);
    step(); chk("t2_req_b", req, 4'b0001);
    step(); chk("t2_req_c", req, 4'b0001);
    step(); chk("t2_req_end", req, 4'b0000);
    gnt = 0;
    // preemption mid-service
    offer(1, 4); step(); c0 = cyc; job_valid = 0;
    step(); gnt = 4'b0010;
    step(2); gnt = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_req_preempt", req, 4'b0010);
      step();
    end
    chk("t3_req_regrant", req, 4'b0010);
    gnt = 4'b0010; expect_done(4'b0010, c0 + 8);
    step(); chk("t3_req_last", req, 4'b0010);
    step(); chk("t3_req_end", req, 4'b0000);
    gnt = 0;
    // zero length stored as one
    offer(2, 0); step(); c0 = cyc; job_valid = 0;
    step(); gnt = 4'b0100; expect_done(4'b0100, c0 + 2);
    step(); chk("t4_req_end", req, 4'b0000);
    gnt = 0;
    // full queue blocks a third job
    offer(3, 5); step(); c0 = cyc; offer(3, 6); step();
    offer(3, 7); #1 chk("t5_ready_full", job_ready, 1'b0);
    step(); job_valid = 0; job_id = 2;
    #1 chk("t5_ready_other", job_ready, 1'b1);
    job_id = 3;
    #1 chk("t5_ready_still_full", job_ready, 1'b0);
    gnt = 4'b1000; expect_done(4'b1000, c0 + 7); expect_done(4'b1000, c0 + 13);
    step(5); chk("t5_req_mid", req, 4'b1000);
    step(6); chk("t5_req_end", req, 4'b0000);
    gnt = 0;
    // protocol errors and reset
    chk("t6_err_clean", err, 1'b0);
    gnt = 4'b0011; step(); chk("t6_err_multi", err, 1'b1);
    gnt = 0; step(); chk("t6_err_sticky", err, 1'b1);
    rst = 0; step(); chk("t6_err_rst", err, 1'b0);
    rst = 1; gnt = 4'b1000; step(); chk("t6_err_noreq", err, 1'b1);
    chk("t6_req_noreq", req, 4'b0000);
    gnt = 0; step(); chk("t6_req_unaltered", req, 4'b0000);
    offer(1, 4); step(); job_valid = 0;
    step(); gnt = 4'b0010;
    step(2); rst = 0; gnt = 0; offer(0, 3);
    step(); job_valid = 0;
    chk("t7_req_rst", req, 4'b0000);
    chk("t7_done_rst", done, 4'b0000);
    chk("t7_err_rst", err, 1'b0);
    job_id = 1; #1 chk("t7_ready1", job_ready, 1'b1);
    job_id = 0; #1 chk("t7_ready0", job_ready, 1'b1);
    rst = 1;
    step(8); chk("t7_no_push_in_rst", req, 4'b0000);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL done_missing exp=%b@%0d", e.d, e.c);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
